// File: rtl/arb_pkg.sv
// Shared types and constants for the one-hot request arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_e;
endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: rotate pend by ptr, find first set, rotate back.
module rr_select
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   ffs;

  always_comb begin
    dbl = {pend, pend} >> ptr;
    rot = dbl[N_REQ-1:0];
    ffs = '0;
    // Scan high to low so the lowest set bit of the rotated word is kept.
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) ffs = IDX_W'(i);
    idx    = ffs + ptr;
    onehot = N_REQ'(1) << idx;
    any    = |pend;
  end
endmodule

// File: rtl/req_onehot_arbiter.sv
// Captures request pulses as sticky pending bits and offers one at a time as a one-hot grant.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed lowest-index priority.
module req_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N = N_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [N-1:0] d,
  output logic         valid,
  output logic [N-1:0] pend
);
  arb_state_e       state, state_n;
  logic [N-1:0]     d_n, pend_n;
  logic             valid_n;
  logic [IDX_W-1:0] gidx, gidx_n;
  logic [N-1:0]     sel_onehot;
  logic [IDX_W-1:0] sel_idx, sel_ptr;
  logic             sel_any;
  logic             accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr, ptr_n;

  assign sel_ptr = ptr;
  assign ptr_n   = accept ? gidx + IDX_W'(1) : ptr;

  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else     ptr <= ptr_n;
`else
  assign sel_ptr = '0;
`endif

  rr_select u_sel (
    .pend   (pend),
    .ptr    (sel_ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign accept = (state == ARB_OFFER) && ready;

  always_comb begin
    state_n = state;
    d_n     = d;
    valid_n = valid;
    gidx_n  = gidx;
    case (state)
      ARB_IDLE:
        if (sel_any) begin
          d_n     = sel_onehot;
          valid_n = 1'b1;
          gidx_n  = sel_idx;
          state_n = ARB_OFFER;
        end
      ARB_OFFER:
        if (ready) begin
          d_n     = '0;
          valid_n = 1'b0;
          state_n = ARB_IDLE;
        end
      default: state_n = ARB_IDLE;
    endcase
    // New requests are OR'ed in after the clear so a same-cycle request wins.
    pend_n = (accept ? (pend & ~(N'(1) << gidx)) : pend) | req;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= ARB_IDLE;
      d     <= '0;
      valid <= 1'b0;
      pend  <= '0;
      gidx  <= '0;
    end else begin
      state <= state_n;
      d     <= d_n;
      valid <= valid_n;
      pend  <= pend_n;
      gidx  <= gidx_n;
    end
endmodule

// File: doc/req_onehot_arbiter.md
# req_onehot_arbiter

Sequential request arbiter that sits directly upstream of the 8-to-3 encoder. It captures up to eight independent request pulses, holds them as pending, and selects one at a time. The selected request is presented as a stable one-hot vector `d[7:0]` with a valid/ready handshake. Because the encoder is only ever fed a legal one-hot word (or all zeros when idle), its 3-bit output is always meaningful.

## Interface
Parameters:
- `N`, 8: number of request lines. Fixed at 8 to match the encoder; other values are unsupported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  8  request lines; each high cycle on bit i marks line i pending
- `ready`  in  1  downstream accepts the current `d` this cycle
- `d`  out  8  registered one-hot grant to the encoder; 8'b0 when not valid
- `valid`  out  1  `d` holds a grant
- `pend`  out  8  registered pending-request vector

## Operation
- Pending register `pend`:
  - Each bit is sticky. `pend[i]` is set the cycle after `req[i]` is seen high.
  - `pend[i]` clears only when grant i is accepted.
  - Set dominates. If `req[i]` is high in the same cycle grant i is accepted, `pend[i]` stays 1.
- FSM states:
  - IDLE: `valid=0`, `d=0`. If `pend != 0`, load `d` with the selected one-hot bit, set `valid=1`, go to OFFER. Otherwise stay in IDLE.
  - OFFER: `d` and `valid` are held stable regardless of `req`. When `ready=1`, clear `pend` at the granted index, update the pointer, drive `d=0` and `valid=0`, and go to IDLE.
- Every accepted grant is followed by one IDLE bubble cycle. Back-to-back grants are therefore at most one every 2 cycles.
- Selection:
  - Uses the `pend` value registered at the IDLE edge. A request arriving in that same cycle is not yet visible.
  - Round-robin: search starts at `ptr` and wraps 7→0. The first set bit wins. After acceptance, `ptr = (granted index + 1) mod 8`, a 3-bit wrap.
- `ready` while in IDLE is ignored.
- `d` is always all-zero or exactly one bit set.
- Reset:
  - `rst` is checked before any other action, in any state including mid-OFFER.
  - `d=0`, `valid=0`, `pend=0`, `ptr=0`, state IDLE. Any outstanding grant is dropped without acceptance.

## Timing
- Request to `valid`, from idle with empty `pend`, takes 2 cycles: edge 1 sets `pend`, edge 2 sets `valid`/`d`.
- Accept: grant leaves on the edge where `valid && ready`. `valid` is low the following cycle.
- Throughput: one grant per 2 cycles with `ready` held high.
- All outputs are registered. There is no combinational path from `req` or `ready` to any output.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin selection with the 3-bit `ptr`, as above.
- Not defined: fixed priority, lowest index wins. `ptr` is not instantiated, and line 0 may starve higher lines.
- Handshake, pending behaviour and timing are identical in both builds.

## Structure
- Package `arb_pkg`:
  - `N_REQ = 8`
  - `IDX_W = 3`
  - state enum `{ARB_IDLE, ARB_OFFER}`
- Sub-module `rr_select`:
  - Combinational.
  - Inputs: `pend[7:0]`, `ptr[2:0]`.
  - Outputs: `onehot[7:0]`, `idx[2:0]`, `any`.
  - Implements rotate, find-first-set and rotate back. In fixed-priority builds it is instantiated with `ptr` tied to 0.

## Test plan
- Reset, then idle 5 cycles: `d=8'b0`, `valid=0`, `pend=8'b0` every cycle.
- Pulse `req=8'b00100000` for 1 cycle with `ready=1`:
  - `pend=8'b00100000` after 1 edge.
  - `valid=1`, `d=8'b00100000` after 2 edges.
  - Accepted on the next edge, then `pend=0`.
- Round-robin, with `ARB_ROUND_ROBIN_EN`: pulse `req=8'b10000011`, `ready=1`. Grant order is `00000001`, `00000010`, `10000000`, each separated by one `valid=0` cycle. Without the macro, the same order follows fixed priority.
- Hold `ready=0` for 6 cycles during OFFER of `d=8'b00000100` while pulsing `req=8'b00000001`:
  - `d` stays `00000100` throughout.
  - `pend=8'b00000101`.
  - After `ready=1`, the next grant is `00000001`.
- `req[2]` high on the same edge that grant `00000100` is accepted: `pend[2]` stays 1, and `d=00000100` is re-granted after the bubble.
- Assert `rst` mid-OFFER with `pend=8'b11110000`: on the next edge all outputs are 0 and `ptr=0`, and no grant is counted as accepted.
